gshare_bp: RTL and testbench

GSHARE_BP -- requirements
Module: gshare_bp

---
 rtl/sys_defs.sv | 23 ++
 rtl/gshare_btb.sv | 51 +++++
 rtl/gshare_bp.sv | 147 ++++++++++++++
 tb/tb_gshare_bp.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared definitions for the gshare branch predictor.
// Holds the default predictor sizes, the global-history type and the BTB
// entry layout. Every predictor file imports this package.
package sys_defs;

    localparam int FETCH_WIDTH  = 2;
    localparam int BHT_ENTRIES  = 256;
    localparam int BTB_ENTRIES  = 64;
    localparam int GHR_BITS     = 8;
    localparam int BTB_TAG_BITS = 10;

    localparam int BHT_IDX_BITS = $clog2(BHT_ENTRIES);
    localparam int BTB_IDX_BITS = $clog2(BTB_ENTRIES);

    typedef logic [GHR_BITS-1:0] GHR_t;

    typedef struct packed {
        logic                    valid;
        logic [BTB_TAG_BITS-1:0] tag;
        logic [63:0]             target;
    } BTBEntry_t;

endpackage

// File: rtl/gshare_btb.sv
// Direct-mapped branch target buffer.
// One combinational read port per fetch lane and one write port, which is
// used by the resolve path.
// Ports:
//   clk, reset           clock, synchronous active-high reset (clears valid bits)
//   rd_idx / rd_tag      per-lane lookup index and tag
//   rd_hit / rd_target   per-lane hit (valid and tag match) and stored target
//   wr_en, wr_idx, wr_tag, wr_target   write/replace one entry
module gshare_btb
    import sys_defs::*;
(
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [FETCH_WIDTH-1:0][BTB_IDX_BITS-1:0]  rd_idx,
    input  logic [FETCH_WIDTH-1:0][BTB_TAG_BITS-1:0]  rd_tag,
    output logic [FETCH_WIDTH-1:0]                    rd_hit,
    output logic [FETCH_WIDTH-1:0][63:0]              rd_target,
    input  logic                                      wr_en,
    input  logic [BTB_IDX_BITS-1:0]                   wr_idx,
    input  logic [BTB_TAG_BITS-1:0]                   wr_tag,
    input  logic [63:0]                               wr_target
);

    BTBEntry_t mem [BTB_ENTRIES];

    // Only the valid bits are cleared on reset; tag and target are don't-care
    // while valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                mem[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            mem[wr_idx].valid  <= 1'b1;
            mem[wr_idx].tag    <= wr_tag;
            mem[wr_idx].target <= wr_target;
        end
    end

    always_comb begin
        BTBEntry_t e;
        rd_hit    = '0;
        rd_target = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            e            = mem[rd_idx[i]];
            rd_hit[i]    = e.valid && (e.tag == rd_tag[i]);
            rd_target[i] = e.target;
        end
    end

endmodule

// File: rtl/gshare_bp.sv
// Gshare branch predictor for a FETCH_WIDTH-wide fetch group.
// Direction comes from a table of 2-bit saturating counters indexed by
// PC xor per-lane global history. Targets come from the gshare_btb
// sub-module. Prediction is purely combinational from registered state.
// Resolve updates become visible on the following cycle.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   if_PC, if_valid                  per-lane PC and lane-valid
//   if_is_cond, if_is_uncond         per-lane branch decode
//   if_accept                        fetch group consumed (history may advance)
//   br_valid, br_PC, br_taken, br_target, br_ghr, br_mispredict
//                                    resolved-branch update port
//   bp_pred_taken, bp_pred_NPC       per-lane direction and next PC
//   bp_lane_live                     lane not squashed by an older taken lane
//   bp_ghr_snap                      history used for each lane's prediction
module gshare_bp
    import sys_defs::*;
(
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [FETCH_WIDTH-1:0][63:0]          if_PC,
    input  logic [FETCH_WIDTH-1:0]                if_valid,
    input  logic [FETCH_WIDTH-1:0]                if_is_cond,
    input  logic [FETCH_WIDTH-1:0]                if_is_uncond,
    input  logic                                  if_accept,
    input  logic                                  br_valid,
    input  logic [63:0]                           br_PC,
    input  logic                                  br_taken,
    input  logic [63:0]                           br_target,
    input  logic [GHR_BITS-1:0]                   br_ghr,
    input  logic                                  br_mispredict,
    output logic [FETCH_WIDTH-1:0]                bp_pred_taken,
    output logic [FETCH_WIDTH-1:0][63:0]          bp_pred_NPC,
    output logic [FETCH_WIDTH-1:0]                bp_lane_live,
    output logic [FETCH_WIDTH-1:0][GHR_BITS-1:0]  bp_ghr_snap
);

    logic [1:0] bht [BHT_ENTRIES];
    GHR_t       ghr;
    GHR_t       fetch_ghr;

    logic [FETCH_WIDTH-1:0][BTB_IDX_BITS-1:0] btb_rd_idx;
    logic [FETCH_WIDTH-1:0][BTB_TAG_BITS-1:0] btb_rd_tag;
    logic [FETCH_WIDTH-1:0]                   btb_hit;
    logic [FETCH_WIDTH-1:0][63:0]             btb_target;

    logic [BHT_IDX_BITS-1:0] br_idx;

    // Only the index and tag fields of the resolve PC are consumed.
    logic unused_br_pc;
    assign unused_br_pc = ^br_PC;

    // BTB lookup depends only on PC, not on history.
    always_comb begin
        btb_rd_idx = '0;
        btb_rd_tag = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            btb_rd_idx[i] = if_PC[i][BTB_IDX_BITS+1:2];
            btb_rd_tag[i] = if_PC[i][BTB_IDX_BITS+BTB_TAG_BITS+1:BTB_IDX_BITS+2];
        end
    end

    gshare_btb u_btb (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (btb_rd_idx),
        .rd_tag    (btb_rd_tag),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .wr_en     (br_valid && br_taken),
        .wr_idx    (br_PC[BTB_IDX_BITS+1:2]),
        .wr_tag    (br_PC[BTB_IDX_BITS+BTB_TAG_BITS+1:BTB_IDX_BITS+2]),
        .wr_target (br_target)
    );

    // Lanes are walked oldest first. Each live branch lane shifts its own
    // predicted direction into the running history seen by younger lanes.
    // The first taken lane squashes everything younger. Squashed lanes
    // neither predict taken nor touch the history.
    always_comb begin
        GHR_t                    hist;
        logic                    squash;
        logic                    live;
        logic                    is_br;
        logic                    taken;
        logic [BHT_IDX_BITS-1:0] idx;

        hist          = ghr;
        squash        = 1'b0;
        live          = 1'b0;
        is_br         = 1'b0;
        taken         = 1'b0;
        idx           = '0;
        bp_pred_taken = '0;
        bp_pred_NPC   = '0;
        bp_lane_live  = '0;
        bp_ghr_snap   = '0;

        for (int i = 0; i < FETCH_WIDTH; i++) begin
            live  = if_valid[i] && !squash;
            is_br = live && (if_is_cond[i] || if_is_uncond[i]);
            idx   = if_PC[i][BHT_IDX_BITS+1:2] ^ BHT_IDX_BITS'(hist);
            taken = is_br && btb_hit[i] && (if_is_uncond[i] || bht[idx][1]);

            bp_ghr_snap[i]   = hist;
            bp_lane_live[i]  = live;
            bp_pred_taken[i] = taken;
            bp_pred_NPC[i]   = taken ? btb_target[i] : if_PC[i] + 64'd4;

            if (is_br) begin
                hist = {hist[GHR_BITS-2:0], taken};
            end
            if (taken) begin
                squash = 1'b1;
            end
        end
        fetch_ghr = hist;
    end

    assign br_idx = br_PC[BHT_IDX_BITS+1:2] ^ BHT_IDX_BITS'(br_ghr);

    // A mispredict restores history from the resolved branch and discards
    // whatever the fetch group would have shifted in this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else begin
            if (br_valid && br_mispredict) begin
                ghr <= {br_ghr[GHR_BITS-2:0], br_taken};
            end else if (if_accept) begin
                ghr <= fetch_ghr;
            end

            if (br_valid) begin
                if (br_taken && (bht[br_idx] != 2'b11)) begin
                    bht[br_idx] <= bht[br_idx] + 2'd1;
                end else if (!br_taken && (bht[br_idx] != 2'b00)) begin
                    bht[br_idx] <= bht[br_idx] - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gshare_bp.sv
module tb_gshare_bp;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0][63:0] if_PC;
    logic [1:0]       if_valid, if_is_cond, if_is_uncond;
    logic             if_accept;
    logic             br_valid, br_taken, br_mispredict;
    logic [63:0]      br_PC, br_target;
    logic [7:0]       br_ghr;
    logic [1:0]       bp_pred_taken, bp_lane_live;
    logic [1:0][63:0] bp_pred_NPC;
    logic [1:0][7:0]  bp_ghr_snap;

    always #5 clk = ~clk;

    gshare_bp dut (
        .clk(clk), .reset(reset),
        .if_PC(if_PC), .if_valid(if_valid), .if_is_cond(if_is_cond),
        .if_is_uncond(if_is_uncond), .if_accept(if_accept),
        .br_valid(br_valid), .br_PC(br_PC), .br_taken(br_taken),
        .br_target(br_target), .br_ghr(br_ghr), .br_mispredict(br_mispredict),
        .bp_pred_taken(bp_pred_taken), .bp_pred_NPC(bp_pred_NPC),
        .bp_lane_live(bp_lane_live), .bp_ghr_snap(bp_ghr_snap)
    );

    typedef struct packed {
        logic [1:0]       tk;
        logic [1:0]       live;
        logic [1:0][63:0] npc;
        logic [1:0][7:0]  snap;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: plain arrays, indices computed arithmetically.
    int unsigned     m_ctr  [256];
    bit              m_bv   [64];
    int unsigned     m_btag [64];
    longint unsigned m_btgt [64];
    int unsigned     m_ghr;
    bit              model_known = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t predict(input bit [1:0] v, c, u,
                                     input longint unsigned pc0, pc1,
                                     output int unsigned fg);
        exp_t            e;
        longint unsigned pcs [2];
        int unsigned     h, bi, ci, tag;
        bit              sq, live, tk, hit;
        pcs[0] = pc0;
        pcs[1] = pc1;
        h  = m_ghr;
        sq = 0;
        e  = '0;
        for (int l = 0; l < 2; l++) begin
            live = v[l] && !sq;
            tk   = 0;
            bi   = int'((pcs[l] >> 2) % 64);
            e.snap[l] = 8'(h);
            e.live[l] = live;
            if (live && (c[l] || u[l])) begin
                tag = int'((pcs[l] >> 8) % 1024);
                hit = m_bv[bi] && (m_btag[bi] == tag);
                ci  = int'((pcs[l] >> 2) % 256) ^ h;
                tk  = hit && (u[l] || m_ctr[ci] >= 2);
                h   = ((h << 1) | int'(tk)) % 256;
                if (tk) sq = 1;
            end
            e.tk[l]  = tk;
            e.npc[l] = tk ? m_btgt[bi] : pcs[l] + 64'd4;
        end
        fg = h;
        return e;
    endfunction

    function automatic void model_update(input bit rst, acc, bv,
                                         input longint unsigned bpc, input bit btk,
                                         input longint unsigned btgt, input int unsigned bghr,
                                         input bit bmis, input int unsigned fg);
        int unsigned ci, bi;
        if (rst) begin
            for (int i = 0; i < 256; i++) m_ctr[i] = 1;
            for (int i = 0; i < 64; i++) m_bv[i] = 0;
            m_ghr = 0;
            model_known = 1;
            return;
        end
        if (bv && bmis) m_ghr = ((bghr << 1) | int'(btk)) % 256;
        else if (acc)   m_ghr = fg;
        if (bv) begin
            ci = int'((bpc >> 2) % 256) ^ bghr;
            if (btk) begin
                if (m_ctr[ci] < 3) m_ctr[ci]++;
                bi = int'((bpc >> 2) % 64);
                m_bv[bi]   = 1;
                m_btag[bi] = int'((bpc >> 8) % 1024);
                m_btgt[bi] = btgt;
            end else if (m_ctr[ci] > 0) begin
                m_ctr[ci]--;
            end
        end
    endfunction

    // One cycle of stimulus: drive just after the edge, push the expected
    // prediction, then advance the model to the state after the next edge.
    task automatic drive(input bit rst, input bit [1:0] v, c, u,
                         input longint unsigned pc0, pc1, input bit acc,
                         input bit bv, input longint unsigned bpc, input bit btk,
                         input longint unsigned btgt, input int unsigned bghr, input bit bmis);
        exp_t        e;
        int unsigned fg = 0;
        @(posedge clk);
        #1;
        reset = rst; if_valid = v; if_is_cond = c; if_is_uncond = u;
        if_PC[0] = pc0; if_PC[1] = pc1; if_accept = acc;
        br_valid = bv; br_PC = bpc; br_taken = btk; br_target = btgt;
        br_ghr = 8'(bghr); br_mispredict = bmis;
        if (model_known) begin
            e = predict(v, c, u, pc0, pc1, fg);
            sb.push_back(e);
        end
        model_update(rst, acc, bv, bpc, btk, btgt, bghr, bmis, fg);
    endtask

    task automatic idle();
        drive(0, 2'b00, 2'b00, 2'b00, 64'h0, 64'h4, 0, 0, 64'h0, 0, 64'h0, 0, 0);
    endtask

    task automatic resolve(input longint unsigned bpc, input bit btk,
                           input longint unsigned btgt, input int unsigned bghr, input bit bmis);
        drive(0, 2'b00, 2'b00, 2'b00, 64'h0, 64'h4, 0, 1, bpc, btk, btgt, bghr, bmis);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_pred_taken", 64'(bp_pred_taken), 64'(e.tk));
            chk("sb_lane_live",  64'(bp_lane_live),  64'(e.live));
            chk("sb_npc0",       bp_pred_NPC[0],     e.npc[0]);
            chk("sb_npc1",       bp_pred_NPC[1],     e.npc[1]);
            chk("sb_snap0",      64'(bp_ghr_snap[0]), 64'(e.snap[0]));
            chk("sb_snap1",      64'(bp_ghr_snap[1]), 64'(e.snap[1]));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    longint unsigned pool [8];

    initial begin
        reset = 1; if_PC = '0; if_valid = '0; if_is_cond = '0; if_is_uncond = '0;
        if_accept = 0; br_valid = 0; br_PC = '0; br_taken = 0; br_target = '0;
        br_ghr = '0; br_mispredict = 0;

        // Reset state: non-branch lanes fall through, all lanes live.
        drive(1, 2'b11, 2'b00, 2'b00, 64'h100, 64'h104, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 2'b11, 2'b00, 2'b00, 64'h100, 64'h104, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_taken", 64'(bp_pred_taken), 64'h0);
        chk("rst_live",  64'(bp_lane_live),  64'h3);
        chk("rst_npc1",  bp_pred_NPC[1],     64'h108);
        chk("rst_snap0", 64'(bp_ghr_snap[0]), 64'h0);

        // Cold conditional branch predicts not taken; history stays zero.
        drive(0, 2'b01, 2'b01, 2'b00, 64'h100, 64'h104, 1, 0, 0, 0, 0, 0, 0);
        #3;
        chk("cold_taken", 64'(bp_pred_taken), 64'h0);
        chk("cold_npc0",  bp_pred_NPC[0],     64'h104);
        resolve(64'h100, 1, 64'h200, 0, 0);
        #3;
        chk("cold_ghr", 64'(bp_ghr_snap[0]), 64'h0);
        resolve(64'h100, 1, 64'h200, 0, 0);

        // Trained branch in lane 0 squashes lane 1; history gains exactly one 1.
        drive(0, 2'b11, 2'b11, 2'b00, 64'h100, 64'h104, 1, 0, 0, 0, 0, 0, 0);
        #3;
        chk("trained_taken", 64'(bp_pred_taken), 64'h1);
        chk("trained_npc0",  bp_pred_NPC[0],     64'h200);
        chk("trained_live",  64'(bp_lane_live),  64'h1);
        idle();
        #3;
        chk("one_shift_ghr", 64'(bp_ghr_snap[0]), 64'h1);

        // Mispredict recovery overrides the same-cycle fetch shift.
        drive(0, 2'b11, 2'b10, 2'b01, 64'h100, 64'h104, 1, 1, 64'h300, 1, 64'h400, 8'h05, 1);
        #3;
        chk("uncond_taken", 64'(bp_pred_taken), 64'h1);
        idle();
        #3;
        chk("mispredict_ghr", 64'(bp_ghr_snap[0]), 64'h0B);

        // Saturation at 11: one more taken then one not-taken still predicts taken.
        resolve(64'h100, 1, 64'h200, 0, 0);
        resolve(64'h100, 0, 64'h0, 0, 0);
        resolve(64'h500, 0, 64'h0, 8'h80, 1);
        drive(0, 2'b01, 2'b01, 2'b00, 64'h100, 64'h104, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("sat_hi_taken", 64'(bp_pred_taken), 64'h1);
        chk("sat_hi_npc0",  bp_pred_NPC[0],     64'h200);

        // Saturation at 00: a third not-taken must not wrap to 11.
        resolve(64'h600, 1, 64'h700, 0, 0);
        resolve(64'h600, 0, 64'h0, 0, 0);
        resolve(64'h600, 0, 64'h0, 0, 0);
        resolve(64'h600, 0, 64'h0, 0, 0);
        drive(0, 2'b01, 2'b01, 2'b00, 64'h600, 64'h604, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("sat_lo_taken", 64'(bp_pred_taken), 64'h0);
        chk("sat_lo_npc0",  bp_pred_NPC[0],     64'h604);

        // Reset mid-stream drops the pending resolve and empties the BTB.
        drive(1, 2'b00, 2'b00, 2'b00, 64'h0, 64'h4, 0, 1, 64'h100, 1, 64'h900, 0, 0);
        drive(0, 2'b01, 2'b01, 2'b00, 64'h100, 64'h104, 0, 1, 64'h100, 1, 64'h200, 0, 0);
        #3;
        chk("post_rst_taken", 64'(bp_pred_taken), 64'h0);
        chk("post_rst_npc0",  bp_pred_NPC[0],     64'h104);
        drive(0, 2'b01, 2'b01, 2'b00, 64'h100, 64'h104, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("post_rst_ctr01", 64'(bp_pred_taken), 64'h1);

        // Randomised traffic against the model.
        for (int i = 0; i < 8; i++) begin
            pool[i] = {$urandom(), $urandom()} & ~64'h3;
            pool[i][63:18] = (i < 4) ? 46'h0 : pool[i][63:18];
        end
        for (int n = 0; n < 800; n++) begin
            bit [1:0]        v, c, u;
            longint unsigned p0, p1, bpc, btgt;
            int unsigned     k;
            for (int l = 0; l < 2; l++) begin
                k    = $urandom_range(0, 2);
                c[l] = (k == 1);
                u[l] = (k == 2);
                v[l] = ($urandom_range(0, 7) != 0);
            end
            p0   = pool[$urandom_range(0, 7)];
            p1   = ($urandom_range(0, 1) == 1) ? p0 + 64'd4 : pool[$urandom_range(0, 7)];
            bpc  = pool[$urandom_range(0, 7)];
            btgt = {$urandom(), $urandom()} & ~64'h3;
            drive($urandom_range(0, 99) == 0, v, c, u, p0, p1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, bpc, $urandom_range(0, 1) == 1, btgt,
                  $urandom_range(0, 255), $urandom_range(0, 3) == 0);
        end

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
